// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - writeback request / regfile write-port bundle
//
// Groups the two writeback requesters' valid/ready handshakes together with
// the registered regfile write port and the status outputs.
//   master : requester/regfile side (drives requests, observes write port)
//   slave  : arbiter side (accepts requests, drives write port and status)
//
// Signals:
//   Req0Valid/Req0Reg/Req0Data/Req0Ready  ALU writeback handshake
//   Req1Valid/Req1Reg/Req1Data/Req1Ready  load/multi-cycle writeback handshake
//   RegWrite/WriteRegister/WriteData      registered regfile write port
//   Busy                                  clear sweep in progress
//   WriteCount                            saturating committed-write count
interface regfile_write_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 5,
    parameter int CW    = 16
);
    logic             Req0Valid;
    logic [AW-1:0]    Req0Reg;
    logic [WIDTH-1:0] Req0Data;
    logic             Req0Ready;
    logic             Req1Valid;
    logic [AW-1:0]    Req1Reg;
    logic [WIDTH-1:0] Req1Data;
    logic             Req1Ready;
    logic             RegWrite;
    logic [AW-1:0]    WriteRegister;
    logic [WIDTH-1:0] WriteData;
    logic             Busy;
    logic [CW-1:0]    WriteCount;

    modport master (
        output Req0Valid, Req0Reg, Req0Data,
        input  Req0Ready,
        output Req1Valid, Req1Reg, Req1Data,
        input  Req1Ready,
        input  RegWrite, WriteRegister, WriteData, Busy, WriteCount
    );

    modport slave (
        input  Req0Valid, Req0Reg, Req0Data,
        output Req0Ready,
        input  Req1Valid, Req1Reg, Req1Data,
        output Req1Ready,
        output RegWrite, WriteRegister, WriteData, Busy, WriteCount
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - regfile write-port owner: clear sweep + round-robin writeback arbiter
//
// After reset, writes zero to registers 1..2**AW-1 (one per cycle), then
// shares the single write port between two writeback requesters with
// round-robin arbitration. A grant is registered onto the write port one
// cycle later. Writes to register 0 are accepted but never issued.
//
// Ports:
//   Clk      clock, all state on posedge
//   Reset_n  asynchronous active-low reset
//   bus      regfile_write_arbiter_if.slave (requests, write port, status)
module regfile_write_arbiter #(
    parameter int WIDTH          = 32,
    parameter int AW             = 5,
    parameter int CLEAR_ON_RESET = 1,
    parameter int CW             = 16
) (
    input logic                    Clk,
    input logic                    Reset_n,
    regfile_write_arbiter_if.slave bus
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

    state_t           state, state_next;
    logic [AW-1:0]    clear_idx, clear_idx_next;
    logic             last, last_next;
    logic             reg_write, reg_write_next;
    logic [AW-1:0]    write_register, write_register_next;
    logic [WIDTH-1:0] write_data, write_data_next;
    logic [CW-1:0]    count, count_next;
    logic             grant0, grant1;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state          <= RESET_STATE;
            clear_idx      <= AW'(1);
            last           <= 1'b1;
            reg_write      <= 1'b0;
            write_register <= '0;
            write_data     <= '0;
            count          <= '0;
        end else begin
            state          <= state_next;
            clear_idx      <= clear_idx_next;
            last           <= last_next;
            reg_write      <= reg_write_next;
            write_register <= write_register_next;
            write_data     <= write_data_next;
            count          <= count_next;
        end
    end

    always_comb begin
        state_next          = state;
        clear_idx_next      = clear_idx;
        last_next           = last;
        reg_write_next      = 1'b0;
        write_register_next = write_register;
        write_data_next     = write_data;
        count_next          = count;
        grant0              = 1'b0;
        grant1              = 1'b0;

        case (state)
            ST_CLEAR: begin
                reg_write_next      = 1'b1;
                write_register_next = clear_idx;
                write_data_next     = '0;
                clear_idx_next      = clear_idx + 1'b1;
                if (clear_idx == {AW{1'b1}}) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // On a tie, the requester that did not win last time goes next.
                grant0 = bus.Req0Valid && (!bus.Req1Valid || last);
                grant1 = bus.Req1Valid && (!bus.Req0Valid || !last);
                if (grant0) begin
                    reg_write_next      = |bus.Req0Reg;
                    write_register_next = bus.Req0Reg;
                    write_data_next     = bus.Req0Data;
                    last_next           = 1'b0;
                    if ((|bus.Req0Reg) && (count != {CW{1'b1}})) begin
                        count_next = count + 1'b1;
                    end
                end else if (grant1) begin
                    reg_write_next      = |bus.Req1Reg;
                    write_register_next = bus.Req1Reg;
                    write_data_next     = bus.Req1Data;
                    last_next           = 1'b1;
                    if ((|bus.Req1Reg) && (count != {CW{1'b1}})) begin
                        count_next = count + 1'b1;
                    end
                end
            end
            default: begin
                state_next = RESET_STATE;
            end
        endcase
    end

    assign bus.Req0Ready     = grant0;
    assign bus.Req1Ready     = grant1;
    assign bus.RegWrite      = reg_write;
    assign bus.WriteRegister = write_register;
    assign bus.WriteData     = write_data;
    assign bus.Busy          = (state == ST_CLEAR);
    assign bus.WriteCount    = count;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

    logic Clk;
    logic Reset_n;
    logic rf_preset;
    logic [31:0] rf [32];

    int n_cmp;
    int n_fail;

    typedef struct {
        logic        v0;
        logic [4:0]  r0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  r1;
        logic [31:0] d1;
        logic        rdy0;
        logic        rdy1;
        logic        wr;
        logic        ca;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic [3:0]  cnt;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    regfile_write_arbiter_if #(.WIDTH(32), .AW(5), .CW(4)) bus ();

    regfile_write_arbiter #(
        .WIDTH(32), .AW(5), .CLEAR_ON_RESET(1), .CW(4)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Behavioural 32x32 register file fed by the write port.
    always @(posedge Clk) begin
        if (rf_preset) begin
            for (int i = 0; i < 32; i++) rf[i] <= (i == 0) ? 32'd0 : (32'hDEAD0000 + 32'(i));
        end else if (bus.RegWrite) begin
            rf[bus.WriteRegister] <= bus.WriteData;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input int k, input int v0, input int r0, input int d0,
                       input int v1, input int r1, input int d1,
                       input int rdy0, input int rdy1, input int wr, input int ca,
                       input int wreg, input int wdata, input int cnt);
        vecs[k].v0    = 1'(v0);
        vecs[k].r0    = 5'(r0);
        vecs[k].d0    = 32'(d0);
        vecs[k].v1    = 1'(v1);
        vecs[k].r1    = 5'(r1);
        vecs[k].d1    = 32'(d1);
        vecs[k].rdy0  = 1'(rdy0);
        vecs[k].rdy1  = 1'(rdy1);
        vecs[k].wr    = 1'(wr);
        vecs[k].ca    = 1'(ca);
        vecs[k].wreg  = 5'(wreg);
        vecs[k].wdata = 32'(wdata);
        vecs[k].cnt   = 4'(cnt);
    endtask

    task automatic idle_inputs();
        bus.Req0Valid = 1'b0;
        bus.Req0Reg   = '0;
        bus.Req0Data  = '0;
        bus.Req1Valid = 1'b0;
        bus.Req1Reg   = '0;
        bus.Req1Data  = '0;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;

        //     k  v0 r0 d0     v1 r1 d1      rdy0 rdy1 wr ca wreg wdata  cnt
        add(0,  1, 2, 42,    0, 0, 0,      1, 0, 1, 1, 2,  42,     1);
        add(1,  0, 0, 0,     1, 7, 77,     0, 1, 1, 1, 7,  77,     2);
        add(2,  1, 5, 15,    1, 6, 283492, 1, 0, 1, 1, 5,  15,     3);
        add(3,  1, 5, 15,    1, 6, 283492, 0, 1, 1, 1, 6,  283492, 4);
        add(4,  1, 5, 15,    1, 6, 283492, 1, 0, 1, 1, 5,  15,     5);
        add(5,  1, 5, 15,    1, 6, 283492, 0, 1, 1, 1, 6,  283492, 6);
        add(6,  0, 0, 0,     0, 0, 0,      0, 0, 0, 1, 6,  283492, 6);
        add(7,  0, 0, 0,     1, 0, 9999,   0, 1, 0, 0, 0,  0,      6);
        add(8,  1, 8, 136,   1, 9, 153,    1, 0, 1, 1, 8,  136,    7);
        add(9,  0, 0, 0,     1, 9, 153,    0, 1, 1, 1, 9,  153,    8);
        add(10, 1, 10, 1000, 0, 0, 0,      1, 0, 1, 1, 10, 1000,   9);
        add(11, 1, 12, 1200, 0, 0, 0,      1, 0, 1, 1, 12, 1200,   10);

        // Reset state, with a request pending that must not be accepted.
        rf_preset = 1'b1;
        Reset_n   = 1'b0;
        idle_inputs();
        bus.Req0Valid = 1'b1;
        bus.Req0Reg   = 5'd3;
        @(negedge Clk);
        @(negedge Clk);
        rf_preset = 1'b0;
        chk("rst RegWrite", 32'(bus.RegWrite), 0);
        chk("rst WriteRegister", 32'(bus.WriteRegister), 0);
        chk("rst WriteData", bus.WriteData, 0);
        chk("rst WriteCount", 32'(bus.WriteCount), 0);
        chk("rst Busy", 32'(bus.Busy), 1);
        chk("rst Req0Ready", 32'(bus.Req0Ready), 0);
        idle_inputs();
        Reset_n = 1'b1;

        // Clear sweep of regs 1..31.
        for (int i = 1; i <= 31; i++) begin
            @(negedge Clk);
            chk($sformatf("clr%0d RegWrite", i), 32'(bus.RegWrite), 1);
            chk($sformatf("clr%0d WriteRegister", i), 32'(bus.WriteRegister), 32'(i));
            chk($sformatf("clr%0d WriteData", i), bus.WriteData, 0);
            chk($sformatf("clr%0d Busy", i), 32'(bus.Busy), (i == 31) ? 0 : 1);
        end
        @(negedge Clk);
        chk("post-clear RegWrite", 32'(bus.RegWrite), 0);
        for (int i = 0; i < 32; i++) chk($sformatf("clr rf[%0d]", i), rf[i], 0);

        // Table-driven RUN vectors.
        for (int k = 0; k < NV; k++) begin
            bus.Req0Valid = vecs[k].v0;
            bus.Req0Reg   = vecs[k].r0;
            bus.Req0Data  = vecs[k].d0;
            bus.Req1Valid = vecs[k].v1;
            bus.Req1Reg   = vecs[k].r1;
            bus.Req1Data  = vecs[k].d1;
            #1;
            chk($sformatf("v%0d Req0Ready", k), 32'(bus.Req0Ready), 32'(vecs[k].rdy0));
            chk($sformatf("v%0d Req1Ready", k), 32'(bus.Req1Ready), 32'(vecs[k].rdy1));
            @(negedge Clk);
            chk($sformatf("v%0d RegWrite", k), 32'(bus.RegWrite), 32'(vecs[k].wr));
            if (vecs[k].ca) begin
                chk($sformatf("v%0d WriteRegister", k), 32'(bus.WriteRegister), 32'(vecs[k].wreg));
                chk($sformatf("v%0d WriteData", k), bus.WriteData, vecs[k].wdata);
            end
            chk($sformatf("v%0d WriteCount", k), 32'(bus.WriteCount), 32'(vecs[k].cnt));
        end

        // Back-to-back Req0 writes driving the counter into saturation.
        for (int i = 0; i < 7; i++) begin
            bus.Req0Valid = 1'b1;
            bus.Req0Reg   = 5'(20 + i);
            bus.Req0Data  = 32'(500 + i);
            bus.Req1Valid = 1'b0;
            #1;
            chk($sformatf("sat%0d Req0Ready", i), 32'(bus.Req0Ready), 1);
            @(negedge Clk);
            chk($sformatf("sat%0d RegWrite", i), 32'(bus.RegWrite), 1);
            chk($sformatf("sat%0d WriteRegister", i), 32'(bus.WriteRegister), 32'(20 + i));
            chk($sformatf("sat%0d WriteCount", i), 32'(bus.WriteCount), (11 + i > 15) ? 15 : 32'(11 + i));
        end
        idle_inputs();
        @(negedge Clk);
        chk("rf[2]", rf[2], 42);
        chk("rf[5]", rf[5], 15);
        chk("rf[6]", rf[6], 283492);
        chk("rf[7]", rf[7], 77);
        chk("rf[0]", rf[0], 0);
        chk("rf[8]", rf[8], 136);
        chk("rf[9]", rf[9], 153);
        chk("rf[12]", rf[12], 1200);
        chk("rf[26]", rf[26], 506);

        // Reset pulse mid-RUN while Req1 is being granted.
        bus.Req1Valid = 1'b1;
        bus.Req1Reg   = 5'd13;
        bus.Req1Data  = 32'd5;
        #1;
        chk("mid Req1Ready", 32'(bus.Req1Ready), 1);
        #1;
        Reset_n = 1'b0;
        #1;
        chk("mid-rst RegWrite", 32'(bus.RegWrite), 0);
        chk("mid-rst WriteRegister", 32'(bus.WriteRegister), 0);
        chk("mid-rst WriteData", bus.WriteData, 0);
        chk("mid-rst WriteCount", 32'(bus.WriteCount), 0);
        chk("mid-rst Busy", 32'(bus.Busy), 1);
        chk("mid-rst Req1Ready", 32'(bus.Req1Ready), 0);
        @(negedge Clk);
        chk("mid-rst held RegWrite", 32'(bus.RegWrite), 0);
        idle_inputs();
        Reset_n = 1'b1;

        // Restarted sweep; Req0 raised at sweep cycle 3 must wait for RUN.
        for (int i = 1; i <= 31; i++) begin
            @(negedge Clk);
            chk($sformatf("clr2 %0d WriteRegister", i), 32'(bus.WriteRegister), 32'(i));
            chk($sformatf("clr2 %0d RegWrite", i), 32'(bus.RegWrite), 1);
            if (i == 1) chk("clr2 WriteCount", 32'(bus.WriteCount), 0);
            if (i == 3) begin
                bus.Req0Valid = 1'b1;
                bus.Req0Reg   = 5'd11;
                bus.Req0Data  = 32'd299;
            end
            if (i >= 3) begin
                #1;
                chk($sformatf("clr2 %0d Req0Ready", i), 32'(bus.Req0Ready), (i == 31) ? 1 : 0);
            end
        end
        @(negedge Clk);
        chk("late RegWrite", 32'(bus.RegWrite), 1);
        chk("late WriteRegister", 32'(bus.WriteRegister), 11);
        chk("late WriteData", bus.WriteData, 299);
        chk("late WriteCount", 32'(bus.WriteCount), 1);
        idle_inputs();
        @(negedge Clk);
        chk("late rf[11]", rf[11], 299);
        chk("late rf[16]", rf[16], 0);
        chk("late rf[18]", rf[18], 0);
        chk("late rf[13]", rf[13], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
